// File: rtl/esc_pkg.sv
// esc_pkg: shared types and widths for the quad ESC PWM generator.
package esc_pkg;
    localparam int SPD_W = 11;
    localparam int CNT_W = 17;
    typedef logic [SPD_W-1:0] spd_t;
    typedef enum logic [1:0] {DISARMED, ARMING, RUN} esc_state_t;
endpackage

// File: rtl/esc_pwm_chan.sv
// esc_pwm_chan: one motor channel; staging and shadow speed, pulse width and comparator.
import esc_pkg::*;
module esc_pwm_chan #(
    parameter int OFFSET_CLKS = 50000,
    parameter int SCALE       = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vld,
    input  logic             bnd,
    input  logic             zero,
    input  logic             en,
    input  spd_t             spd,
    input  logic [CNT_W-1:0] cnt,
    output logic             pwm
);
    spd_t stg, shd;
    logic [CNT_W-1:0] width;
    assign width = CNT_W'(OFFSET_CLKS) + CNT_W'(shd) * CNT_W'(SCALE);
    always_ff @(posedge clk) begin
        if (rst) begin
            stg <= '0;
            shd <= '0;
            pwm <= 1'b0;
        end else begin
            if (vld) stg <= spd;
            if (bnd) shd <= zero ? '0 : stg;
            pwm <= en && (cnt < width);
        end
    end
endmodule

// File: rtl/esc_quad_pwm.sv
// esc_quad_pwm: four ESC pulse trains with arming sequence and frame-aligned updates.
// Define ESC_WDOG_EN to drop to offset-only pulses after WDOG_FRAMES frames without vld.
import esc_pkg::*;
module esc_quad_pwm #(
    parameter int PERIOD_CLKS = 125000,
    parameter int OFFSET_CLKS = 50000,
    parameter int SCALE       = 24,
    parameter int ARM_FRAMES  = 100,
    parameter int WDOG_FRAMES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic vld,
    input  spd_t frnt_spd,
    input  spd_t bck_spd,
    input  spd_t lft_spd,
    input  spd_t rght_spd,
    input  logic arm,
    output logic frnt_pwm,
    output logic bck_pwm,
    output logic lft_pwm,
    output logic rght_pwm,
    output logic armed,
    output logic frm_strt
);
    localparam int AW = $clog2(ARM_FRAMES + 1);
    logic [CNT_W-1:0] cnt;
    logic [AW-1:0] acnt;
    esc_state_t state, state_nxt;
    logic bnd, wdog_trip;
    logic [3:0] pwm;
    spd_t spd [4];
    assign bnd = cnt == '0;
    assign armed = state == RUN;
    assign spd = '{frnt_spd, bck_spd, lft_spd, rght_spd};
    assign {rght_pwm, lft_pwm, bck_pwm, frnt_pwm} = pwm;
    always_comb begin
        state_nxt = state;
        if (!arm)
            state_nxt = DISARMED;
        else if (bnd)
            state_nxt = state == DISARMED ? ARMING :
                        (state == ARMING && acnt == AW'(ARM_FRAMES - 1)) ? RUN : state;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            frm_strt <= 1'b0;
            state    <= DISARMED;
            acnt     <= '0;
        end else begin
            cnt      <= cnt == CNT_W'(PERIOD_CLKS - 1) ? '0 : cnt + 1'b1;
            frm_strt <= cnt == CNT_W'(PERIOD_CLKS - 1);
            state    <= state_nxt;
            if (bnd) acnt <= state == ARMING ? acnt + 1'b1 : '0;
        end
    end
`ifdef ESC_WDOG_EN
    localparam int WW = $clog2(WDOG_FRAMES + 1);
    logic [WW-1:0] wcnt;
    assign wdog_trip = wcnt == WW'(WDOG_FRAMES);
    always_ff @(posedge clk) begin
        if (rst || vld)
            wcnt <= '0;
        else if (bnd && !wdog_trip)
            wcnt <= wcnt + 1'b1;
    end
`else
    assign wdog_trip = 1'b0 && (WDOG_FRAMES > 0);
`endif
    for (genvar g = 0; g < 4; g++) begin : g_chan
        esc_pwm_chan #(.OFFSET_CLKS(OFFSET_CLKS), .SCALE(SCALE)) u_chan (
            .clk (clk),
            .rst (rst),
            .vld (vld),
            .bnd (bnd),
            .zero(state_nxt != RUN || wdog_trip),
            .en  (state_nxt != DISARMED),
            .spd (spd[g]),
            .cnt (cnt),
            .pwm (pwm[g])
        );
    end
endmodule

// File: tb/tb_esc_quad_pwm.sv
// tb_esc_quad_pwm: directed frame-by-frame pulse width checks on a scaled-down configuration.
import esc_pkg::*;
module tb_esc_quad_pwm;
    localparam int P = 2100, OFF = 20, SC = 1, ARMF = 3, WDF = 3;
    logic clk = 0, rst = 1, vld = 0, arm = 1;
    spd_t fs = '0, bs = '0, ls = '0, rs = '0;
    logic fp, bp, lp, rp, armed, frm_strt;
    int checks = 0, errors = 0, len;
    int w[4];
    logic a;

    always #5 clk = ~clk;

    esc_quad_pwm #(.PERIOD_CLKS(P), .OFFSET_CLKS(OFF), .SCALE(SC), .ARM_FRAMES(ARMF),
                   .WDOG_FRAMES(WDF)) dut (
        .clk(clk), .rst(rst), .vld(vld), .frnt_spd(fs), .bck_spd(bs), .lft_spd(ls),
        .rght_spd(rs), .arm(arm), .frnt_pwm(fp), .bck_pwm(bp), .lft_pwm(lp),
        .rght_pwm(rp), .armed(armed), .frm_strt(frm_strt)
    );

    function automatic int wd(int s);
        return OFF + s * SC;
    endfunction

    task automatic chk(string tag, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Measures one frame from a frm_strt (or reset release) negedge up to the next frm_strt.
    task automatic frame(int vld_at);
        w = '{0, 0, 0, 0};
        len = 0;
        a = 1'b0;
        vld = (vld_at == 0);
        do begin
            @(negedge clk);
            len++;
            vld = (len == vld_at);
            if (len == 1) a = armed;
            if (!frm_strt) begin
                w[0] += int'(fp);
                w[1] += int'(bp);
                w[2] += int'(lp);
                w[3] += int'(rp);
            end
        end while (!frm_strt && len < 2 * P);
        if (!frm_strt) chk("frame_timeout", 0, 1);
    endtask

    task automatic chk_frame(string tag, int e0, int e1, int e2, int e3, int ea);
        chk({tag, ".frnt"}, w[0], e0);
        chk({tag, ".bck"}, w[1], e1);
        chk({tag, ".lft"}, w[2], e2);
        chk({tag, ".rght"}, w[3], e3);
        chk({tag, ".armed"}, int'(a), ea);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_pwm", int'({fp, bp, lp, rp}), 0);
        chk("rst_armed", int'(armed), 0);
        chk("rst_frm_strt", int'(frm_strt), 0);
        rst = 0;
        for (int k = 0; k < ARMF; k++) begin
            frame(-1);
            if (k == 0) chk("arm_len", len, P);
            chk_frame("arming", OFF, OFF, OFF, OFF, 0);
        end
        frame(-1);
        chk_frame("run0", OFF, OFF, OFF, OFF, 1);
        fs = 11'h100; bs = 11'h000; ls = 11'h7FF; rs = 11'h001;
        frame(0);
        chk_frame("vec_bnd", OFF, OFF, OFF, OFF, 1);
        frame(-1);
        chk_frame("vec", wd(256), wd(0), wd(2047), wd(1), 1);
        fs = 11'h200;
        frame(100);
        chk_frame("mid_old", wd(256), wd(0), wd(2047), wd(1), 1);
        frame(-1);
        chk_frame("mid_new", wd(512), wd(0), wd(2047), wd(1), 1);
        repeat (5) @(negedge clk);
        chk("dis_pre", int'(fp), 1);
        arm = 0;
        @(negedge clk);
        chk("dis_pwm", int'({fp, bp, lp, rp}), 0);
        chk("dis_armed", int'(armed), 0);
        arm = 1;
        frame(-1);
        chk_frame("dis_rest", 0, 0, 0, 0, 0);
        for (int k = 0; k < ARMF; k++) begin
            frame(-1);
            chk_frame("rearm", OFF, OFF, OFF, OFF, 0);
        end
        frame(-1);
        chk_frame("rearm_run", wd(512), wd(0), wd(2047), wd(1), 1);
        repeat (5) @(negedge clk);
        chk("rst_mid_pre", int'(fp), 1);
        rst = 1;
        @(negedge clk);
        chk("rst_mid_pwm", int'({fp, bp, lp, rp}), 0);
        chk("rst_mid_armed", int'(armed), 0);
        chk("rst_mid_frm", int'(frm_strt), 0);
        rst = 0;
        for (int k = 0; k < ARMF; k++) begin
            frame(-1);
            if (k == 0) chk("rst_mid_len", len, P);
            chk_frame("rst_arming", OFF, OFF, OFF, OFF, 0);
        end
        frame(-1);
        chk_frame("rst_run", OFF, OFF, OFF, OFF, 1);
        fs = 11'h100; bs = 11'h100; ls = 11'h000; rs = 11'h000;
        frame(0);
        chk_frame("wd_load", OFF, OFF, OFF, OFF, 1);
        for (int k = 0; k < WDF; k++) begin
            frame(-1);
            chk_frame("wd_hold", wd(256), wd(256), wd(0), wd(0), 1);
        end
        frame(50);
`ifdef ESC_WDOG_EN
        chk_frame("wd_trip", OFF, OFF, OFF, OFF, 1);
`else
        chk_frame("wd_persist", wd(256), wd(256), wd(0), wd(0), 1);
`endif
        frame(-1);
        chk_frame("wd_restore", wd(256), wd(256), wd(0), wd(0), 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/esc_quad_pwm.md
Name: esc_quad_pwm

Overview:
- Consumer end of the flight controller motor-speed interface: takes four 11-bit unsigned motor speeds (front/back/left/right) plus a valid strobe and drives four ESC PWM pulse trains.
- Double-buffers speeds so pulse widths change only at frame boundaries.
- Enforces an arming sequence (minimum-throttle pulses) before commanded speeds reach the motors.
- Sits between flght_cntrl and the ESC pins at the quadcopter top level.

Parameters:
- PERIOD_CLKS, 125000: clocks per PWM frame (400 Hz at 50 MHz).
- OFFSET_CLKS, 50000: pulse width for speed 0 (1 ms).
- SCALE, 24: clocks per speed LSB. Max width is 50000+2047*24 = 99128 < PERIOD_CLKS.
- ARM_FRAMES, 100: number of zero-speed frames emitted before RUN.
- WDOG_FRAMES, 8: frames without vld before failsafe. Used only with ESC_WDOG_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- vld  in  1  speed bundle valid strobe, one cycle
- frnt_spd  in  11  front motor speed, unsigned
- bck_spd  in  11  back motor speed
- lft_spd  in  11  left motor speed
- rght_spd  in  11  right motor speed
- arm  in  1  level; 1 requests motors armed
- frnt_pwm  out  1  front ESC pulse
- bck_pwm  out  1  back ESC pulse
- lft_pwm  out  1  left ESC pulse
- rght_pwm  out  1  right ESC pulse
- armed  out  1  high only in RUN
- frm_strt  out  1  one-cycle pulse when the frame counter is 0

Behaviour:
- Reset: all pwm outputs 0, armed 0, frm_strt 0, frame counter 0, staging and shadow speeds 0, state DISARMED, arm-frame counter 0. Reset is synchronous and takes effect mid-pulse; the next cycle's outputs are the reset values.
- Frame counter: 17 bits, counts 0..PERIOD_CLKS-1 and wraps. frm_strt is registered and asserts on the cycle the counter equals 0.
- Staging registers: on vld, capture all four speeds the next cycle. The last vld wins. A vld coincident with the frame boundary lands in staging but not in shadow until the next boundary.
- Shadow registers: at counter==0, shadow <= staging in RUN, or 0 in DISARMED/ARMING.
- Width per channel: OFFSET_CLKS + shadow*SCALE, 17 bits, no overflow by parameter constraint.
- pwm output: registered; pwm = (state != DISARMED) && (counter < width). Each pulse starts the cycle after counter==0, so latency from frm_strt to pwm rising edge is 1 cycle.
- State DISARMED: pwm held 0. Leaves when arm=1 is sampled at a frame boundary; moves to ARMING and clears the arm-frame counter.
- State ARMING: emits OFFSET_CLKS-wide pulses. The arm-frame counter increments each boundary. After ARM_FRAMES boundaries, moves to RUN at that boundary and loads shadow from staging the same cycle.
- State RUN: armed=1; emits commanded widths.
- Disarm: arm=0 in any state moves to DISARMED on the next cycle. pwm is forced 0 immediately, truncating any in-flight pulse. Shadow is cleared at the next boundary.
- Re-arm: always restarts the full ARM_FRAMES sequence.
- Speeds are used unclamped; full 11-bit range is legal.

Optional Feature:
- Macro: ESC_WDOG_EN.
- With it: a frame counter tracks boundaries since the last vld. When it reaches WDOG_FRAMES in RUN, the shadow loads 0 at boundaries (OFFSET-only pulses) until the next vld. The block stays armed. Any vld clears the counter.
- Without it: the last staged speeds persist indefinitely; the WDOG_FRAMES parameter is unused.

Decomposition:
- Shared package esc_pkg holds:
  - the state enum typedef esc_state_t {DISARMED, ARMING, RUN};
  - SPD_W=11 and CNT_W=17 localparams;
  - the typedef spd_t logic [10:0].
- Sub-module esc_pwm_chan, instantiated four times: staging register, shadow register, width multiply-add, and comparator. The top holds the frame counter, the FSM, and the watchdog.

Test Plan:
- Reset mid-RUN with pwm high: next cycle all pwm=0, armed=0; frm_strt resumes at counter 0.
- arm=1 held from reset: frames 1..100 give 50000-clk pulses with armed=0; frame 101 gives armed=1.
- RUN, vld with frnt=0x100, bck=0, lft=0x7FF, rght=0x001: from the next frame, pulse widths are 56144, 50000, 99128, 50024 clks.
- vld with 0x200 mid-frame: the current frame keeps its old width; the next frame gives 62288.
- arm dropped mid-pulse: pwm=0 the next cycle. Re-arm at the next boundary: 100 ARMING frames before RUN.
- ESC_WDOG_EN: RUN at speed 0x100, then no vld for 8 frames: the 9th frame is 50000 clks with armed=1. A new vld restores 56144 at the following frame.
